// File: rtl/masked_subbytes_serial.sv
// Byte-serial SubBytes sequencer: streams a shared 128-bit state through a
// pipelined masked S-box one byte per cycle and reassembles the result.
module masked_subbytes_serial #(
    parameter int NUM_SHARES   = 2,
    parameter int SBOX_LATENCY = 3
) (
    input  logic                           in_clock,
    input  logic                           in_reset,
    input  logic                           in_valid,
    output logic                           out_ready,
    input  logic [NUM_SHARES-1:0][127:0]   in_state,
    input  logic                           in_enc,
    output logic [NUM_SHARES-1:0][7:0]     out_sbox_a,
    output logic                           out_sbox_enc,
    input  logic [NUM_SHARES-1:0][7:0]     in_sbox_b,
    output logic                           out_valid,
    input  logic                           in_ready,
    output logic [NUM_SHARES-1:0][127:0]   out_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                         state_r;
    state_t                         state_next_s;
    logic [NUM_SHARES-1:0][127:0]   latch_r;
    logic [NUM_SHARES-1:0][127:0]   latch_next_s;
    logic [NUM_SHARES-1:0][127:0]   result_r;
    logic [NUM_SHARES-1:0][127:0]   result_next_s;
    logic                           enc_r;
    logic                           enc_next_s;
    logic [3:0]                     issue_cnt_r;
    logic [3:0]                     issue_cnt_next_s;
    logic [4:0]                     capt_cnt_r;
    logic [4:0]                     capt_cnt_next_s;
    logic [SBOX_LATENCY-1:0]        track_r;
    logic [SBOX_LATENCY-1:0]        track_next_s;
    logic [NUM_SHARES-1:0][7:0]     sbox_a_r;
    logic [NUM_SHARES-1:0][7:0]     sbox_a_next_s;
    logic                           ready_r;
    logic                           valid_r;
    logic                           feed_s;
    logic                           capture_s;

    // Each share is selected independently; shares are never combined.
    function automatic logic [NUM_SHARES-1:0][7:0] pick_byte(
        input logic [NUM_SHARES-1:0][127:0] st,
        input logic [3:0]                   idx
    );
        logic [NUM_SHARES-1:0][7:0] b;
        for (int s = 0; s < NUM_SHARES; s++) begin
            b[s] = st[s][{idx, 3'b000} +: 8];
        end
        return b;
    endfunction

    // Issue tracker shift and the capture strobe emerging from it
    always_comb begin
        feed_s       = (state_r == FEED);
        capture_s    = track_r[SBOX_LATENCY-1] & ~capt_cnt_r[4];
        track_next_s = (track_r << 1'b1) | SBOX_LATENCY'(feed_s);
    end

    // Next-state, counters, byte issue and result capture
    always_comb begin
        state_next_s     = state_r;
        latch_next_s     = latch_r;
        enc_next_s       = enc_r;
        issue_cnt_next_s = issue_cnt_r;
        capt_cnt_next_s  = capt_cnt_r;
        result_next_s    = result_r;
        sbox_a_next_s    = '0;

        if (capture_s) begin
            for (int s = 0; s < NUM_SHARES; s++) begin
                result_next_s[s][{capt_cnt_r[3:0], 3'b000} +: 8] = in_sbox_b[s];
            end
            capt_cnt_next_s = capt_cnt_r + 5'd1;
        end else begin
            capt_cnt_next_s = capt_cnt_r;
        end

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    latch_next_s     = in_state;
                    enc_next_s       = in_enc;
                    issue_cnt_next_s = 4'd0;
                    capt_cnt_next_s  = 5'd0;
                    sbox_a_next_s    = pick_byte(in_state, 4'd0);
                    state_next_s     = FEED;
                end else begin
                    state_next_s     = IDLE;
                end
            end
            FEED: begin
                issue_cnt_next_s = issue_cnt_r + 4'd1;
                if (issue_cnt_r == 4'd15) begin
                    sbox_a_next_s = '0;
                    state_next_s  = DRAIN;
                end else begin
                    sbox_a_next_s = pick_byte(latch_r, issue_cnt_r + 4'd1);
                    state_next_s  = FEED;
                end
            end
            DRAIN: begin
                // Leave on the edge that captures byte 15 so out_valid is not delayed.
                if (capture_s && (capt_cnt_r == 5'd15)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            DONE: begin
                if (in_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, datapath and registered output update
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_r     <= IDLE;
            latch_r     <= '0;
            result_r    <= '0;
            enc_r       <= 1'b0;
            issue_cnt_r <= 4'd0;
            capt_cnt_r  <= 5'd0;
            track_r     <= '0;
            sbox_a_r    <= '0;
            ready_r     <= 1'b1;
            valid_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            latch_r     <= latch_next_s;
            result_r    <= result_next_s;
            enc_r       <= enc_next_s;
            issue_cnt_r <= issue_cnt_next_s;
            capt_cnt_r  <= capt_cnt_next_s;
            track_r     <= track_next_s;
            sbox_a_r    <= sbox_a_next_s;
            ready_r     <= (state_next_s == IDLE);
            valid_r     <= (state_next_s == DONE);
        end
    end

    assign out_ready    = ready_r;
    assign out_valid    = valid_r;
    assign out_sbox_a   = sbox_a_r;
    assign out_sbox_enc = enc_r;
    assign out_state    = result_r;

endmodule

// File: tb/tb_masked_subbytes_serial.sv
// Directed bench for masked_subbytes_serial: three instances (latency 3, 1, 15)
// each fed by a stub S-box pipeline of matching depth.
module tb_masked_subbytes_serial;

    typedef logic [1:0][127:0] st_t;
    typedef logic [1:0][7:0]   sb_t;

    typedef struct {
        int   wait_cyc;
        logic rdy_acc;
        st_t  seen;
        int   enc_bad;
        sb_t  drain_a;
        int   lat;
        st_t  result;
        int   hold_bad;
        logic rdy_hs;
        logic vld_hs;
    } obs_t;

    logic clk;
    logic rst_n;
    logic valid_in  [3];
    logic ready_in  [3];
    logic ready_out [3];
    logic valid_out [3];
    logic enc_out   [3];
    sb_t  sbox_a    [3];
    sb_t  sbox_b    [3];
    st_t  state_out [3];
    st_t  state_in;
    logic enc_in;
    logic stub_mode;
    int   checks = 0;
    int   passes = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, s;
        r = 8'h01; s = x;
        for (int i = 1; i < 8; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = ginv(x);
        return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        return ginv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
    endfunction

    function automatic sb_t stub_f(input sb_t a, input logic enc);
        sb_t r;
        logic [7:0] x;
        if (stub_mode == 1'b0) begin
            r = a;
        end else begin
            x = a[0] ^ a[1];
            r[0] = enc ? fwd_sbox(x) : inv_sbox(x);
            r[1] = 8'h00;
        end
        return r;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 3 : ((g == 1) ? 1 : 15);
        sb_t pipe [LAT];

        masked_subbytes_serial #(.NUM_SHARES(2), .SBOX_LATENCY(LAT)) dut (
            .in_clock     (clk),
            .in_reset     (rst_n),
            .in_valid     (valid_in[g]),
            .out_ready    (ready_out[g]),
            .in_state     (state_in),
            .in_enc       (enc_in),
            .out_sbox_a   (sbox_a[g]),
            .out_sbox_enc (enc_out[g]),
            .in_sbox_b    (sbox_b[g]),
            .out_valid    (valid_out[g]),
            .in_ready     (ready_in[g]),
            .out_state    (state_out[g])
        );

        always @(posedge clk) begin
            pipe[0] <= stub_f(sbox_a[g], enc_out[g]);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign sbox_b[g] = pipe[LAT-1];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction on instance d and records what was observed.
    task automatic run_txn(input int d, input st_t st, input logic enc,
                           input int hold, input st_t nxt, output obs_t o);
        o = '{default: '0};
        while (ready_out[d] !== 1'b1 && o.wait_cyc < 200) begin
            tick();
            o.wait_cyc++;
        end
        state_in = st; enc_in = enc; valid_in[d] = 1'b1;
        tick();
        valid_in[d] = 1'b0;
        o.rdy_acc = ready_out[d];
        for (int k = 0; k < 16; k++) begin
            for (int s = 0; s < 2; s++) o.seen[s][8*k +: 8] = sbox_a[d][s];
            if (enc_out[d] !== enc) o.enc_bad++;
            tick();
        end
        o.drain_a = sbox_a[d];
        o.lat = -1;
        for (int c = 17; c < 60; c++) begin
            if (valid_out[d] === 1'b1) begin
                o.lat = c - 1;
                break;
            end
            if (enc_out[d] !== enc) o.enc_bad++;
            tick();
        end
        o.result = state_out[d];
        if (hold > 0) begin
            valid_in[d] = 1'b1;
            state_in = nxt;
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            if (valid_out[d] !== 1'b1 || ready_out[d] !== 1'b0 || state_out[d] !== o.result)
                o.hold_bad++;
        end
        ready_in[d] = 1'b1;
        tick();
        ready_in[d] = 1'b0;
        o.rdy_hs = ready_out[d];
        o.vld_hs = valid_out[d];
    endtask

    task automatic test_reset();
        rst_n = 1'b0; state_in = '0; enc_in = 1'b0; stub_mode = 1'b0;
        for (int d = 0; d < 3; d++) begin
            valid_in[d] = 1'b0;
            ready_in[d] = 1'b0;
        end
        repeat (3) tick();
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (ready_out[d] !== 1'b1) $display("FAIL idle_ready dut%0d got %b want 1", d, ready_out[d]);
                else passes++;
                checks++;
                if (valid_out[d] !== 1'b0) $display("FAIL idle_valid dut%0d got %b want 0", d, valid_out[d]);
                else passes++;
                checks++;
                if (sbox_a[d] !== 16'h0000) $display("FAIL idle_sbox_a dut%0d got %h want 0000", d, sbox_a[d]);
                else passes++;
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (state_out[d] !== '0) $display("FAIL reset_state dut%0d got %h want 0", d, state_out[d]);
            else passes++;
            checks++;
            if (enc_out[d] !== 1'b0) $display("FAIL reset_enc dut%0d got %b want 0", d, enc_out[d]);
            else passes++;
        end
    endtask

    task automatic test_identity();
        st_t v [2];
        logic e [2];
        obs_t o;
        stub_mode = 1'b0;
        v[0] = {128'h0, 128'h000102030405060708090A0B0C0D0E0F}; e[0] = 1'b1;
        v[1] = {128'hA5A5A5A55A5A5A5A0F0F0F0FF0F0F0F0, 128'hDEADBEEF0BADF00DCAFEBABE12345678}; e[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            run_txn(0, v[i], e[i], 0, '0, o);
            checks++;
            if (o.rdy_acc !== 1'b0) $display("FAIL ident_ready_after_accept v%0d got %b want 0", i, o.rdy_acc);
            else passes++;
            checks++;
            if (o.seen !== v[i]) $display("FAIL ident_issue_order v%0d got %h want %h", i, o.seen, v[i]);
            else passes++;
            checks++;
            if (o.enc_bad !== 0) $display("FAIL ident_enc v%0d got %0d bad cycles want 0", i, o.enc_bad);
            else passes++;
            checks++;
            if (o.drain_a !== 16'h0000) $display("FAIL ident_drain_zero v%0d got %h want 0000", i, o.drain_a);
            else passes++;
            checks++;
            if (o.lat !== 19) $display("FAIL ident_latency v%0d got %0d want 19", i, o.lat);
            else passes++;
            checks++;
            if (o.result !== v[i]) $display("FAIL ident_result v%0d got %h want %h", i, o.result, v[i]);
            else passes++;
            checks++;
            if (o.rdy_hs !== 1'b1 || o.vld_hs !== 1'b0)
                $display("FAIL ident_after_handshake v%0d got ready=%b valid=%b want ready=1 valid=0", i, o.rdy_hs, o.vld_hs);
            else passes++;
        end
    endtask

    task automatic test_sbox();
        st_t v [3];
        st_t x [3];
        logic e [3];
        obs_t o;
        stub_mode = 1'b1;
        v[0] = {128'h0, 128'h0};                                       e[0] = 1'b1;
        x[0] = {128'h0, {16{8'h63}}};
        v[1] = {128'h0, {16{8'h63}}};                                  e[1] = 1'b0;
        x[1] = {128'h0, 128'h0};
        v[2] = {128'h0123456789ABCDEFFEDCBA9876543210,
                128'h0123456789ABCDEFFEDCBA9876543210 ^ {16{8'h63}}};  e[2] = 1'b0;
        x[2] = {128'h0, 128'h0};
        for (int i = 0; i < 3; i++) begin
            run_txn(0, v[i], e[i], 0, '0, o);
            checks++;
            if (o.seen !== v[i]) $display("FAIL sbox_issue v%0d got %h want %h", i, o.seen, v[i]);
            else passes++;
            checks++;
            if (o.result !== x[i]) $display("FAIL sbox_result v%0d got %h want %h", i, o.result, x[i]);
            else passes++;
        end
        stub_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        st_t a, b;
        obs_t o;
        stub_mode = 1'b0;
        a = {128'h1111222233334444555566667777AAAA, 128'h89ABCDEF0011223344556677FEDCBA98};
        b = {128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 128'h13579BDF2468ACE0FDB97531ECA86420};
        run_txn(0, a, 1'b1, 10, b, o);
        checks++;
        if (o.hold_bad !== 0) $display("FAIL bp_hold_stable got %0d unstable cycles want 0", o.hold_bad);
        else passes++;
        checks++;
        if (o.result !== a) $display("FAIL bp_result got %h want %h", o.result, a);
        else passes++;
        checks++;
        if (o.rdy_hs !== 1'b1 || o.vld_hs !== 1'b0)
            $display("FAIL bp_no_accept_on_handshake got ready=%b valid=%b want ready=1 valid=0", o.rdy_hs, o.vld_hs);
        else passes++;
        run_txn(0, b, 1'b1, 0, '0, o);
        checks++;
        if (o.wait_cyc !== 0) $display("FAIL bp_accept_next_cycle got %0d wait cycles want 0", o.wait_cyc);
        else passes++;
        checks++;
        if (o.seen !== b) $display("FAIL bp_second_issue got %h want %h", o.seen, b);
        else passes++;
        checks++;
        if (o.result !== b) $display("FAIL bp_second_result got %h want %h", o.result, b);
        else passes++;
    endtask

    task automatic test_reset_midflight();
        st_t a, b;
        sb_t exp7;
        obs_t o;
        int guard;
        stub_mode = 1'b0;
        a = {128'h8F8E8D8C8B8A89888786858483828180, 128'h1F1E1D1C1B1A19181716151413121110};
        b = {128'hCFCECDCCCBCAC9C8C7C6C5C4C3C2C1C0, 128'h4F4E4D4C4B4A49484746454443424140};
        exp7 = {8'h87, 8'h17};
        guard = 0;
        while (ready_out[0] !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        state_in = a; enc_in = 1'b1; valid_in[0] = 1'b1;
        tick();
        valid_in[0] = 1'b0;
        repeat (7) tick();
        checks++;
        if (sbox_a[0] !== exp7) $display("FAIL mid_byte7 got %h want %h", sbox_a[0], exp7);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sbox_a[0] !== 16'h0000 || enc_out[0] !== 1'b0)
            $display("FAIL mid_reset_sbox got a=%h enc=%b want a=0000 enc=0", sbox_a[0], enc_out[0]);
        else passes++;
        checks++;
        if (ready_out[0] !== 1'b1 || valid_out[0] !== 1'b0)
            $display("FAIL mid_reset_hs got ready=%b valid=%b want ready=1 valid=0", ready_out[0], valid_out[0]);
        else passes++;
        checks++;
        if (state_out[0] !== '0) $display("FAIL mid_reset_state got %h want 0", state_out[0]);
        else passes++;
        tick();
        tick();
        rst_n = 1'b1;
        run_txn(0, b, 1'b1, 0, '0, o);
        checks++;
        if (o.seen !== b) $display("FAIL mid_new_issue got %h want %h", o.seen, b);
        else passes++;
        checks++;
        if (o.lat !== 19) $display("FAIL mid_new_latency got %0d want 19", o.lat);
        else passes++;
        checks++;
        if (o.result !== b) $display("FAIL mid_new_result got %h want %h", o.result, b);
        else passes++;
    endtask

    task automatic test_latency_sweep();
        st_t c1, c15;
        obs_t o;
        stub_mode = 1'b0;
        c1  = {128'h00112233445566778899AABBCCDDEEFF, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F};
        c15 = {128'h5555AAAA5555AAAA3333CCCC3333CCCC, 128'h0102040810204080FEFDFBF7EFDFBF7F};
        run_txn(1, c1, 1'b1, 0, '0, o);
        checks++;
        if (o.lat !== 17) $display("FAIL lat1_latency got %0d want 17", o.lat);
        else passes++;
        checks++;
        if (o.seen !== c1) $display("FAIL lat1_issue got %h want %h", o.seen, c1);
        else passes++;
        checks++;
        if (o.result !== c1) $display("FAIL lat1_result got %h want %h", o.result, c1);
        else passes++;
        run_txn(2, c15, 1'b0, 0, '0, o);
        checks++;
        if (o.lat !== 31) $display("FAIL lat15_latency got %0d want 31", o.lat);
        else passes++;
        checks++;
        if (o.enc_bad !== 0) $display("FAIL lat15_enc got %0d bad cycles want 0", o.enc_bad);
        else passes++;
        checks++;
        if (o.result !== c15) $display("FAIL lat15_result got %h want %h", o.result, c15);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_identity();
        test_sbox();
        test_backpressure();
        test_reset_midflight();
        test_latency_sweep();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired passed=%0d total=%0d", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
